// File: rtl/intt_fsm.sv
// rtl/intt_fsm.sv - Gentleman-Sande inverse NTT controller with final 256^-1 scaling
module intt_fsm #(
    parameter logic [22:0] Q     = 23'd8380417,
    parameter logic [22:0] N_INV = 23'd8347681,
    parameter int          AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_INTT,
    output logic          busy,
    output logic          done_INTT,
    output logic [AW-1:0] A0,
    output logic [23:0]   D0,
    output logic          WEB0,
    input  logic [23:0]   Q0,
    output logic [AW-1:0] A1,
    output logic [23:0]   D1,
    output logic          WEB1,
    input  logic [23:0]   Q1,
    output logic [45:0]   red_in,
    input  logic [22:0]   red_out
);

    typedef enum logic [2:0] {
        IDLE, LEN_LOOP, START_LOOP, J_READ, J_WRITE, SCALE_READ, SCALE_WRITE, DONE
    } state_t;

    state_t      state;
    logic [8:0]  len, start, j, k;
    logic [22:0] z;

    // zeta[i] = 1753^brv8(i) mod Q, evaluated at elaboration
    function automatic logic [22:0] zeta_calc(input int idx);
        logic [7:0]      ib, e;
        longint unsigned acc, base, qq;
        ib   = idx[7:0];
        qq   = 64'(Q);
        acc  = 64'd1;
        base = 64'd1753;
        for (int b = 0; b < 8; b++) e[b] = ib[7-b];
        for (int b = 0; b < 8; b++) begin
            if (e[b]) acc = (acc * base) % qq;
            base = (base * base) % qq;
        end
        return acc[22:0];
    endfunction

    logic [22:0] zeta_rom [256];
    for (genvar g = 0; g < 256; g++) begin : g_rom
        localparam logic [22:0] ZV = zeta_calc(g);
        assign zeta_rom[g] = ZV;
    end

    logic [22:0] t, u, add_r, sub_r;
    logic [23:0] sum, dif;
    logic [7:0]  zidx;
    logic [8:0]  jn;
    logic        unused_ok;

    assign t         = Q1[22:0];
    assign u         = Q0[22:0];
    assign sum       = {1'b0, t} + {1'b0, u};
    assign dif       = {1'b0, t} - {1'b0, u};
    assign add_r     = (sum >= {1'b0, Q}) ? 23'(sum - {1'b0, Q}) : sum[22:0];
    assign sub_r     = (t < u) ? 23'(dif + {1'b0, Q}) : dif[22:0];
    // k = 256 wraps to index 255 in 8 bits, which is exactly the first zeta needed
    assign zidx      = k[7:0] - 8'd1;
    assign jn        = j + 9'd1;
    assign unused_ok = ^{Q0[23], Q1[23], k[8]};

    always_comb begin
        red_in = '0;
        D0     = '0;
        D1     = '0;
        if (state == J_WRITE) begin
            red_in = {23'd0, z} * {23'd0, sub_r};
            D0     = {1'b0, red_out};
            D1     = {1'b0, add_r};
        end else if (state == SCALE_WRITE) begin
            red_in = {23'd0, t} * {23'd0, N_INV};
            D1     = {1'b0, red_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done_INTT <= 1'b0;
            WEB0      <= 1'b1;
            WEB1      <= 1'b1;
            A0        <= '0;
            A1        <= '0;
            len       <= '0;
            start     <= '0;
            j         <= '0;
            k         <= '0;
            z         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_INTT <= 1'b0;
                    WEB0      <= 1'b1;
                    WEB1      <= 1'b1;
                    if (start_INTT) begin
                        len   <= 9'd1;
                        k     <= 9'd256;
                        start <= '0;
                        busy  <= 1'b1;
                        state <= LEN_LOOP;
                    end
                end
                LEN_LOOP: begin
                    if (len < 9'd256) begin
                        start <= '0;
                        state <= START_LOOP;
                    end else begin
                        j     <= '0;
                        A1    <= '0;
                        A0    <= AW'(128);
                        state <= SCALE_READ;
                    end
                end
                START_LOOP: begin
                    if (start < 9'd256) begin
                        k     <= k - 9'd1;
                        z     <= Q - zeta_rom[zidx];
                        j     <= start;
                        A1    <= AW'(start);
                        A0    <= AW'(start + len);
                        state <= J_READ;
                    end else begin
                        len   <= len << 1;
                        state <= LEN_LOOP;
                    end
                end
                J_READ: begin
                    WEB0  <= 1'b0;
                    WEB1  <= 1'b0;
                    state <= J_WRITE;
                end
                J_WRITE: begin
                    WEB0 <= 1'b1;
                    WEB1 <= 1'b1;
                    if (j == start + len - 9'd1) begin
                        start <= start + (len << 1);
                        state <= START_LOOP;
                    end else begin
                        j     <= jn;
                        A1    <= AW'(jn);
                        A0    <= AW'(jn + len);
                        state <= J_READ;
                    end
                end
                SCALE_READ: begin
                    WEB1  <= 1'b0;
                    state <= SCALE_WRITE;
                end
                SCALE_WRITE: begin
                    WEB1 <= 1'b1;
                    if (j == 9'd255) begin
                        done_INTT <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        j     <= jn;
                        A1    <= AW'(jn);
                        // park port 0 half a polynomial away so the ports never share a word
                        A0    <= AW'({~jn[7], jn[6:0]});
                        state <= SCALE_READ;
                    end
                end
                DONE: begin
                    done_INTT <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
